// File: rtl/instruction_memory_sync_pkg.sv
// rtl/instruction_memory_sync_pkg.sv - shared constants and types for the instruction memory
// Holds the RISC-V NOP encoding, the fixed instruction width, the fault-cause
// enum and the sequencer state type used by the top level.
package instruction_memory_sync_pkg;

    localparam int INST_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0] RV_NOP = 32'h00000013;

    typedef enum logic [0:0] {
        MISALIGN = 1'b0,
        RANGE    = 1'b1
    } fault_cause_e;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

endpackage

// File: rtl/instruction_memory_sync_if.sv
// rtl/instruction_memory_sync_if.sv - fetch and program port bundle of the instruction memory
// Signals:
//   fetch_req/fetch_addr/fetch_ready  fetch request handshake (byte address)
//   stall                             hazard-unit stall, freezes the fetch outputs
//   inst_valid/instruction/inst_pc/fault  registered fetch response
//   prog_we/prog_addr/prog_data/prog_ready  word write handshake
//   init_done                         memory cleared and usable
// master = IF stage / loader side, slave = memory side.
interface instruction_memory_sync_if #(
    parameter int ADDR_WIDTH = 64
);
    import instruction_memory_sync_pkg::*;

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  stall;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  fault;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [INST_WIDTH-1:0] prog_data;
    logic                  prog_ready;
    logic                  init_done;

    modport master (
        output fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
        input  fetch_ready, inst_valid, instruction, inst_pc, fault, prog_ready, init_done
    );

    modport slave (
        input  fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
        output fetch_ready, inst_valid, instruction, inst_pc, fault, prog_ready, init_done
    );

endinterface

// File: rtl/instruction_memory_sync_word_ram.sv
// rtl/instruction_memory_sync_word_ram.sv - 1R1W synchronous word RAM, read-first
// Ports:
//   clk            clock
//   re/raddr/rdata registered read; rdata holds its value while re=0
//   we/waddr/wdata synchronous write
// A same-address read and write in one cycle returns the old word.
module instruction_memory_sync_word_ram #(
    parameter int INDEX_W   = 8,
    parameter int WIDTH     = 32,
    parameter     INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               re,
    input  logic [INDEX_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata
);

    logic [WIDTH-1:0] mem [2**INDEX_W];

    // Both updates are non-blocking, so the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_memory_sync.sv
// rtl/instruction_memory_sync.sv - synchronous instruction memory with NOP clear sequencer
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    instruction_memory_sync_if.slave: fetch, program and status signals
// After reset a CLEAR pass writes NOP to every word, then RUN serves fetches
// with one-cycle latency and accepts program-port word writes.
module instruction_memory_sync
    import instruction_memory_sync_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DEPTH_BYTES    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter     INIT_FILE      = ""
) (
    input  logic                          clk,
    input  logic                          reset,
    instruction_memory_sync_if.slave      bus
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW    = $clog2(WORDS);
    // Full-width limit so upper address bits take part in the range test.
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH_BYTES);

    imem_state_e state_q;
    imem_state_e state_d;
    logic [IW-1:0] clr_cnt_q;

    logic                  ram_we;
    logic [IW-1:0]         ram_waddr;
    logic [INST_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [INST_WIDTH-1:0] ram_rdata;

    logic fetch_fault;
    logic prog_in_range;
    logic accept;
    logic from_ram_q;

    assign fetch_fault   = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr >= LIMIT);
    assign prog_in_range = (bus.prog_addr < LIMIT);
    assign accept        = bus.fetch_req & bus.fetch_ready;
    // Faulting fetches never touch the array.
    assign ram_re        = accept & ~fetch_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.fetch_ready = 1'b0;
        bus.prog_ready  = 1'b0;
        bus.init_done   = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = bus.prog_addr[IW+1:2];
        ram_wdata       = bus.prog_data;
        case (state_q)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET) begin
                    state_d = ST_RUN;
                end else begin
                    ram_we    = 1'b1;
                    ram_waddr = clr_cnt_q;
                    ram_wdata = RV_NOP;
                    if (clr_cnt_q == IW'(WORDS - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                bus.init_done   = 1'b1;
                bus.prog_ready  = 1'b1;
                bus.fetch_ready = ~bus.stall;
                ram_we          = bus.prog_we & prog_in_range;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Response registers freeze entirely while stalled; from_ram_q picks
    // between the RAM read register and the NOP returned for faults/reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.inst_valid <= 1'b0;
            bus.inst_pc    <= '0;
            bus.fault      <= 1'b0;
            from_ram_q     <= 1'b0;
        end else if (!bus.stall) begin
            bus.inst_valid <= accept;
            if (accept) begin
                bus.inst_pc <= bus.fetch_addr;
                bus.fault   <= fetch_fault;
                from_ram_q  <= ~fetch_fault;
            end
        end
    end

    assign bus.instruction = from_ram_q ? ram_rdata : RV_NOP;

    instruction_memory_sync_word_ram #(
        .INDEX_W   (IW),
        .WIDTH     (INST_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (bus.fetch_addr[IW+1:2]),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

endmodule

// File: tb/tb_instruction_memory_sync.sv
// tb/tb_instruction_memory_sync.sv - scoreboard bench for instruction_memory_sync
module tb_instruction_memory_sync;
    import instruction_memory_sync_pkg::*;

    localparam int AW = 64;
    localparam int DB = 64;
    localparam int NW = DB / 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_memory_sync_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_memory_sync #(
        .ADDR_WIDTH     (AW),
        .DEPTH_BYTES    (DB),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m[NW];
    bit          run_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per fresh response; during a stall the
    // outputs must repeat the last response.
    initial begin
        exp_t e;
        exp_t last;
        logic s;
        bit   held_valid;
        held_valid = 0;
        last = '{RV_NOP, 64'd0, 1'b0};
        forever begin
            @(posedge clk);
            s = bus.stall;
            @(negedge clk);
            if (reset !== 1'b1) begin
                held_valid = 0;
                last = '{RV_NOP, 64'd0, 1'b0};
            end else if (s) begin
                chk("stall_valid", bus.inst_valid, held_valid);
                if (held_valid) begin
                    chk("stall_instr", bus.instruction, last.instr);
                    chk("stall_pc", bus.inst_pc, last.pc);
                    chk("stall_fault", bus.fault, last.fault);
                end
            end else if (bus.inst_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 required=0 pc=%h", bus.inst_pc);
                    held_valid = 1;
                end else begin
                    e = q.pop_front();
                    chk("instr", bus.instruction, e.instr);
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("fault", bus.fault, e.fault);
                    last = e;
                    held_valid = 1;
                end
            end else begin
                held_valid = 0;
            end
        end
    end

    task automatic idle_inputs();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
    endtask

    task automatic check_reset_vals();
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_instruction", bus.instruction, 64'h13);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_fetch_ready", bus.fetch_ready, 0);
        chk("rst_prog_ready", bus.prog_ready, 0);
    endtask

    // Called with reset already low; releases it on a falling edge and
    // checks init_done appears after exactly NW rising edges.
    task automatic release_and_init();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= NW; k++) begin
            @(posedge clk);
            #1;
            chk("init_done", bus.init_done, (k == NW));
            chk("init_fetch_ready", bus.fetch_ready, (k == NW) && !bus.stall);
            chk("init_inst_valid", bus.inst_valid, 0);
        end
        for (int i = 0; i < NW; i++) mem_m[i] = RV_NOP;
        run_m = 1;
    endtask

    // One clock of stimulus; expectations come from the word-array model.
    task automatic cyc(input bit req, input logic [63:0] a, input bit st,
                       input bit we, input logic [63:0] pa, input logic [31:0] pd);
        exp_t e;
        bit   f;
        bus.fetch_req  = req;
        bus.fetch_addr = a;
        bus.stall      = st;
        bus.prog_we    = we;
        bus.prog_addr  = pa;
        bus.prog_data  = pd;
        @(negedge clk);
        chk("fetch_ready", bus.fetch_ready, run_m && !st);
        chk("prog_ready", bus.prog_ready, run_m);
        if (run_m && req && !st) begin
            f = (a[1:0] != 2'b00) || (a >= 64'(DB));
            e.pc    = a;
            e.fault = f;
            e.instr = f ? RV_NOP : mem_m[a[5:2]];
            q.push_back(e);
        end
        if (run_m && we && (pa < 64'(DB))) mem_m[pa[5:2]] = pd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom % 8;
        if (r < 5)       return {58'd0, 4'($urandom % NW), 2'b00};
        else if (r == 5) return {58'd0, 4'($urandom % NW), 2'($urandom % 3 + 1)};
        else if (r == 6) return 64'(DB) + 64'({$urandom % 16, 2'b00});
        else             return 64'h8000_0000_0000_0000 | {58'd0, 4'($urandom % NW), 2'b00};
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        release_and_init();

        // Program three words, then fetch them back to back.
        cyc(0, 0, 0, 1, 64'd0, 32'h00500193);
        cyc(0, 0, 0, 1, 64'd4, 32'h00300233);
        cyc(0, 0, 0, 1, 64'd8, 32'h000202b3);
        cyc(1, 64'd0, 0, 0, 0, 0);
        cyc(1, 64'd4, 0, 0, 0, 0);
        cyc(1, 64'd8, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Misaligned and out-of-range fetches.
        cyc(1, 64'h6, 0, 0, 0, 0);
        cyc(1, 64'h40, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Stall hold after a fetch of word 1.
        cyc(1, 64'd4, 0, 0, 0, 0);
        cyc(1, 64'd0, 1, 0, 0, 0);
        cyc(1, 64'd0, 1, 0, 0, 0);
        cyc(1, 64'd0, 1, 0, 0, 0);
        cyc(1, 64'd8, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Same-cycle write and fetch of one word is read-first.
        cyc(1, 64'd8, 0, 1, 64'd8, 32'hDEADBEEF);
        cyc(1, 64'd8, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset in the middle of the clear pass.
        reset = 1'b0;
        q.delete();
        run_m = 0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        release_and_init();

        // Reset while a fetch request is pending; nothing may come out.
        cyc(0, 0, 0, 1, 64'd12, 32'h12345678);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 64'd12;
        #3;
        reset = 1'b0;
        q.delete();
        run_m = 0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        release_and_init();
        idle_inputs();
        cyc(1, 64'd12, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, rand_addr(), ($urandom % 5) == 0,
                ($urandom % 3) == 0, rand_addr(), $urandom);
        end
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drain", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
